// File: rtl/sample_arbiter_if.sv
// -----------------------------------------------------------------------------
// sample_arbiter_if
//
// Purpose: bundles the tick inputs, the per-source enable and overrun-clear
// controls, the status outputs and the req/ack/done handshake to the shared
// sampling engine into one interface. It is used between sample_arbiter and
// its environment.
//
// Signals:
//   tick_in     [NSRC] timer square waves, synchronous to clk
//   src_en      [NSRC] per-source enable
//   smp_req            request to the sampling engine, held until ack
//   smp_src     [3]    index of the granted source
//   smp_ack            engine accepted the request (1-cycle pulse)
//   smp_done           engine finished the sample (1-cycle pulse)
//   busy               arbiter is in REQ or BUSY
//   ovr_flags   [NSRC] sticky per-source overrun
//   ovr_clr     [NSRC] per-bit clear of ovr_flags
//   timeout_err        1-cycle pulse on a watchdog abort
//
// Modports:
//   master - the arbiter side (drives the request and the status)
//   slave  - the environment side (timer, control registers, engine)
// -----------------------------------------------------------------------------
interface sample_arbiter_if #(
   parameter int NSRC = 5
);
   logic [NSRC-1:0] tick_in;
   logic [NSRC-1:0] src_en;
   logic            smp_req;
   logic [2:0]      smp_src;
   logic            smp_ack;
   logic            smp_done;
   logic            busy;
   logic [NSRC-1:0] ovr_flags;
   logic [NSRC-1:0] ovr_clr;
   logic            timeout_err;

   modport master (
      input  tick_in,
      input  src_en,
      input  smp_ack,
      input  smp_done,
      input  ovr_clr,
      output smp_req,
      output smp_src,
      output busy,
      output ovr_flags,
      output timeout_err
   );

   modport slave (
      output tick_in,
      output src_en,
      output smp_ack,
      output smp_done,
      output ovr_clr,
      input  smp_req,
      input  smp_src,
      input  busy,
      input  ovr_flags,
      input  timeout_err
   );
endinterface

// File: rtl/sample_arbiter.sv
// -----------------------------------------------------------------------------
// sample_arbiter
//
// Purpose: shares one sampling engine among the five rate ticks of the sample
// timer. A rising edge on an enabled tick raises that source's pending bit. A
// round-robin search, which starts just after the last granted source, picks
// one pending source. The source is then served over a req/ack/done
// handshake. If a tick rises while that source is still pending, its sticky
// overrun flag is set. A watchdog aborts a transaction that stays too long in
// REQ or BUSY.
//
// Parameters:
//   TIMEOUT  watchdog limit in cycles (legal 2..65535)
//   NSRC     number of tick sources (fixed at 5)
//
// Ports:
//   clk   system clock
//   rst   asynchronous, active-high reset
//   bus   sample_arbiter_if.master: ticks, enables, overrun flags/clear,
//         engine handshake, busy and timeout_err
// -----------------------------------------------------------------------------
module sample_arbiter #(
   parameter int TIMEOUT = 10000,
   parameter int NSRC    = 5
) (
   input  logic               clk,
   input  logic               rst,
   sample_arbiter_if.master   bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_BUSY = 2'd2
   } state_t;

   // The watchdog aborts on the edge where it would reach TIMEOUT-1.
   localparam logic [15:0] WDOG_LAST  = 16'(TIMEOUT - 1);
   localparam logic [2:0]  LAST_RESET = 3'(NSRC - 1);

   // ---------------------------------------------------------------- state
   state_t          r_state;
   logic [NSRC-1:0] r_tick_d;
   logic [NSRC-1:0] r_pend;
   logic [NSRC-1:0] r_ovr;
   logic [2:0]      r_last;
   logic [2:0]      r_smp_src;
   logic            r_smp_req;
   logic            r_busy;
   logic            r_timeout_err;
   logic [15:0]     r_wdog;

   // ---------------------------------------------------------------- wires
   logic [NSRC-1:0] w_rise;
   logic [NSRC-1:0] w_grant_mask;
   logic [NSRC-1:0] w_ovr_set;
   logic [NSRC-1:0] w_pend_next;
   logic [NSRC-1:0] w_ovr_next;
   logic            w_grant_valid;
   logic            w_grant_fire;
   logic [2:0]      w_grant_idx;
   logic [15:0]     w_wdog_inc;
   logic            w_wdog_expire;

   // (base + off) mod NSRC. The caller keeps off in 1..NSRC, so one subtract is enough.
   function automatic logic [2:0] f_wrap(input logic [2:0] base, input int unsigned off);
      int unsigned s;
      s = int'(base) + off;
      if (s >= NSRC) begin
         s = s - NSRC;
      end
      return s[2:0];
   endfunction

   // ----------------------------------------------------- round-robin search
   // Walk the candidates from farthest to nearest. The nearest pending
   // source after r_last is written last, so it wins.
   always_comb begin
      w_grant_valid = 1'b0;
      w_grant_idx   = 3'd0;
      for (int k = NSRC; k >= 1; k--) begin
         if (r_pend[f_wrap(r_last, k)]) begin
            w_grant_valid = 1'b1;
            w_grant_idx   = f_wrap(r_last, k);
         end
      end
   end

   assign w_grant_fire  = (r_state == ST_IDLE) && w_grant_valid;
   assign w_wdog_inc    = r_wdog + 16'd1;
   assign w_wdog_expire = (w_wdog_inc == WDOG_LAST);

   // ------------------------------------------------ per-source bookkeeping
   generate
      for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
         assign w_rise[gi]       = bus.tick_in[gi] & ~r_tick_d[gi] & bus.src_en[gi];
         assign w_grant_mask[gi] = w_grant_fire && (w_grant_idx == 3'(gi));
         // A rise on the source being granted this cycle re-arms pend
         // instead of counting as an overrun.
         assign w_ovr_set[gi]    = w_rise[gi] & r_pend[gi] & ~w_grant_mask[gi];
         assign w_pend_next[gi]  = bus.src_en[gi] &
                                   ((r_pend[gi] & ~w_grant_mask[gi]) | w_rise[gi]);
         // A new overrun wins over a clear in the same cycle.
         assign w_ovr_next[gi]   = w_ovr_set[gi] | (r_ovr[gi] & ~bus.ovr_clr[gi]);
      end
   endgenerate

   // r_tick_d resets to all ones. A tick that is already high when reset
   // is released is then not seen as a fresh edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tick_d <= '1;
         r_pend   <= '0;
         r_ovr    <= '0;
      end else begin
         r_tick_d <= bus.tick_in;
         r_pend   <= w_pend_next;
         r_ovr    <= w_ovr_next;
      end
   end

   // ------------------------------------------------------------------ FSM
   // All outputs are registered here. The watchdog restarts from zero on
   // every state change. An aborted source is dropped and is not re-queued.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_smp_req     <= 1'b0;
         r_smp_src     <= 3'd0;
         r_busy        <= 1'b0;
         r_timeout_err <= 1'b0;
         r_last        <= LAST_RESET;
         r_wdog        <= 16'd0;
      end else begin
         r_timeout_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_wdog <= 16'd0;
               if (w_grant_fire) begin
                  r_state   <= ST_REQ;
                  r_smp_src <= w_grant_idx;
                  r_last    <= w_grant_idx;
                  r_smp_req <= 1'b1;
                  r_busy    <= 1'b1;
               end
            end

            ST_REQ: begin
               if (bus.smp_ack && bus.smp_done) begin
                  r_state   <= ST_IDLE;
                  r_smp_req <= 1'b0;
                  r_busy    <= 1'b0;
                  r_wdog    <= 16'd0;
               end else if (bus.smp_ack) begin
                  r_state   <= ST_BUSY;
                  r_smp_req <= 1'b0;
                  r_wdog    <= 16'd0;
               end else if (w_wdog_expire) begin
                  r_state       <= ST_IDLE;
                  r_smp_req     <= 1'b0;
                  r_busy        <= 1'b0;
                  r_timeout_err <= 1'b1;
                  r_wdog        <= 16'd0;
               end else begin
                  // smp_done without smp_ack is ignored here.
                  r_wdog <= w_wdog_inc;
               end
            end

            ST_BUSY: begin
               if (bus.smp_done) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_wdog  <= 16'd0;
               end else if (w_wdog_expire) begin
                  r_state       <= ST_IDLE;
                  r_busy        <= 1'b0;
                  r_timeout_err <= 1'b1;
                  r_wdog        <= 16'd0;
               end else begin
                  r_wdog <= w_wdog_inc;
               end
            end

            default: begin
               r_state   <= ST_IDLE;
               r_smp_req <= 1'b0;
               r_busy    <= 1'b0;
               r_wdog    <= 16'd0;
            end
         endcase
      end
   end

   // -------------------------------------------------------------- outputs
   assign bus.smp_req     = r_smp_req;
   assign bus.smp_src     = r_smp_src;
   assign bus.busy        = r_busy;
   assign bus.ovr_flags   = r_ovr;
   assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_sample_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sample_arbiter
//
// Self-checking bench for sample_arbiter with TIMEOUT=50. Each time a tick is
// driven, the bench pushes the expected grant index to a queue. Each new
// smp_req pops that queue and compares the index with smp_src. Latencies,
// overrun flags, watchdog timing and reset behaviour are checked directly.
// -----------------------------------------------------------------------------
module tb_sample_arbiter;
   localparam int TIMEOUT = 50;

   logic clk = 1'b0;
   logic rst;

   sample_arbiter_if #(.NSRC(5)) bus ();

   sample_arbiter #(
      .TIMEOUT (TIMEOUT),
      .NSRC    (5)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_q[$];

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for smp_req and then checks the granted index against
   // the next scoreboard entry.
   task automatic wait_req(input string tag, output int cycles);
      int exp_src;
      cycles = 0;
      while (bus.smp_req !== 1'b1 && cycles < 200) begin
         step();
         cycles++;
      end
      check_value({tag, "_req"}, 32'(bus.smp_req), 32'd1);
      exp_src = (exp_q.size() > 0) ? exp_q.pop_front() : 7;
      check_value({tag, "_src"}, 32'(bus.smp_src), 32'(exp_src));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int cyc;
      int cnt;

      rst          = 1'b1;
      bus.tick_in  = '0;
      bus.src_en   = '0;
      bus.smp_ack  = 1'b0;
      bus.smp_done = 1'b0;
      bus.ovr_clr  = '0;
      repeat (3) step();

      // ---- reset values
      check_value("rst_req",   32'(bus.smp_req),     32'd0);
      check_value("rst_src",   32'(bus.smp_src),     32'd0);
      check_value("rst_busy",  32'(bus.busy),        32'd0);
      check_value("rst_ovr",   32'(bus.ovr_flags),   32'd0);
      check_value("rst_tmo",   32'(bus.timeout_err), 32'd0);
      rst = 1'b0;
      step();

      // ---- single source: 2-cycle latency, ack, then done
      bus.src_en  = 5'b00001;
      bus.tick_in = 5'b00001;
      exp_q.push_back(0);
      step();
      check_value("t1_lat1_req", 32'(bus.smp_req), 32'd0);
      step();
      check_value("t1_lat2_req", 32'(bus.smp_req), 32'd1);
      wait_req("t1", cyc);
      check_value("t1_busy", 32'(bus.busy), 32'd1);
      step();
      bus.smp_ack = 1'b1;
      step();
      bus.smp_ack = 1'b0;
      check_value("t1_ack_req",  32'(bus.smp_req), 32'd0);
      check_value("t1_ack_busy", 32'(bus.busy),    32'd1);
      step();
      step();
      bus.tick_in = '0;
      check_value("t1_predone_busy", 32'(bus.busy), 32'd1);
      bus.smp_done = 1'b1;
      step();
      bus.smp_done = 1'b0;
      check_value("t1_done_busy", 32'(bus.busy), 32'd0);
      step();
      check_value("t1_idle_req", 32'(bus.smp_req), 32'd0);

      // ---- round-robin from reset; second burst uses combined ack+done
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      bus.src_en = 5'b11111;
      for (int b = 0; b < 2; b++) begin
         bus.tick_in = 5'b11111;
         for (int i = 0; i < 5; i++) exp_q.push_back(i);
         for (int i = 0; i < 5; i++) begin
            wait_req($sformatf("t2_b%0d_g%0d", b, i), cyc);
            if (b == 0) begin
               bus.smp_ack = 1'b1;
               step();
               bus.smp_ack = 1'b0;
               check_value($sformatf("t2_b%0d_g%0d_ackreq", b, i), 32'(bus.smp_req), 32'd0);
               bus.smp_done = 1'b1;
               step();
               bus.smp_done = 1'b0;
               check_value($sformatf("t2_b%0d_g%0d_busy", b, i), 32'(bus.busy), 32'd0);
            end else begin
               bus.smp_ack  = 1'b1;
               bus.smp_done = 1'b1;
               step();
               bus.smp_ack  = 1'b0;
               bus.smp_done = 1'b0;
               check_value($sformatf("t2_b%0d_g%0d_busy", b, i), 32'(bus.busy),    32'd0);
               check_value($sformatf("t2_b%0d_g%0d_req",  b, i), 32'(bus.smp_req), 32'd0);
            end
         end
         bus.tick_in = '0;
         step();
         step();
      end

      // ---- overrun on src 1 while src 0 sits in REQ, then REQ watchdog
      bus.src_en  = 5'b00011;
      bus.tick_in = 5'b00001;
      exp_q.push_back(0);
      wait_req("t3_src0", cyc);
      cnt = 0;
      bus.tick_in = 5'b00011;
      step(); cnt++;
      check_value("t3_ovr_first", 32'(bus.ovr_flags), 32'd0);
      bus.tick_in = 5'b00001;
      repeat (9) begin step(); cnt++; end
      bus.tick_in = 5'b00011;
      step(); cnt++;
      check_value("t3_ovr_second", 32'(bus.ovr_flags), 32'b00010);
      check_value("t3_req_held",   32'(bus.smp_req),   32'd1);
      bus.ovr_clr = 5'b00010;
      step(); cnt++;
      bus.ovr_clr = '0;
      check_value("t3_ovr_clr", 32'(bus.ovr_flags), 32'd0);
      bus.smp_done = 1'b1;
      step(); cnt++;
      bus.smp_done = 1'b0;
      check_value("t3_done_ignored", 32'(bus.smp_req), 32'd1);
      exp_q.push_back(1);
      while (bus.timeout_err !== 1'b1 && cnt < 100) begin step(); cnt++; end
      check_value("t3_req_wdog_cycles", 32'(cnt), 32'd49);
      check_value("t3_abort_req",  32'(bus.smp_req), 32'd0);
      check_value("t3_abort_busy", 32'(bus.busy),    32'd0);
      wait_req("t3_src1", cyc);
      check_value("t3_regrant_gap", 32'(cyc), 32'd1);

      // ---- BUSY watchdog: ack, no done, new pend on src 0 meanwhile
      bus.smp_ack = 1'b1;
      step();
      bus.smp_ack = 1'b0;
      check_value("t4_busy",   32'(bus.busy),    32'd1);
      check_value("t4_reqlow", 32'(bus.smp_req), 32'd0);
      cnt = 0;
      bus.tick_in = 5'b00010;
      step(); cnt++;
      bus.tick_in = 5'b00011;
      step(); cnt++;
      exp_q.push_back(0);
      while (bus.timeout_err !== 1'b1 && cnt < 100) begin step(); cnt++; end
      check_value("t4_busy_wdog_cycles", 32'(cnt), 32'd49);
      check_value("t4_abort_busy", 32'(bus.busy), 32'd0);
      step();
      check_value("t4_tmo_pulse", 32'(bus.timeout_err), 32'd0);
      check_value("t4_next_req",  32'(bus.smp_req),     32'd1);
      wait_req("t4_next", cyc);
      bus.smp_ack  = 1'b1;
      bus.smp_done = 1'b1;
      step();
      bus.smp_ack  = 1'b0;
      bus.smp_done = 1'b0;

      // ---- disabling src 2 while it is pending drops the request
      bus.tick_in = '0;
      step();
      bus.src_en  = 5'b00101;
      bus.tick_in = 5'b00001;
      exp_q.push_back(0);
      wait_req("t5_src0", cyc);
      bus.smp_ack = 1'b1;
      step();
      bus.smp_ack = 1'b0;
      bus.tick_in = 5'b00101;
      step();
      bus.src_en = 5'b00001;
      step();
      bus.smp_done = 1'b1;
      step();
      bus.smp_done = 1'b0;
      check_value("t5_done_busy", 32'(bus.busy), 32'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         check_value($sformatf("t5_no_grant_%0d", i), 32'(bus.smp_req), 32'd0);
      end

      // ---- asynchronous reset during BUSY, tick held high afterwards
      bus.src_en  = 5'b00101;
      bus.tick_in = '0;
      step();
      bus.tick_in = 5'b00100;
      exp_q.push_back(2);
      wait_req("t6_src2", cyc);
      bus.smp_ack = 1'b1;
      step();
      bus.smp_ack = 1'b0;
      check_value("t6_busy", 32'(bus.busy), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check_value("t6_rst_busy", 32'(bus.busy),        32'd0);
      check_value("t6_rst_src",  32'(bus.smp_src),     32'd0);
      check_value("t6_rst_req",  32'(bus.smp_req),     32'd0);
      check_value("t6_rst_tmo",  32'(bus.timeout_err), 32'd0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check_value($sformatf("t6_no_spurious_%0d", i), 32'(bus.smp_req), 32'd0);
      end

      check_value("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
